// File: rtl/dotprod_pkg.sv
// Shared types and constants for the dot-product accelerator.
package dotprod_pkg;

    // Default number of fractional bits (Q16.16)
    localparam int unsigned FRAC_BITS_DEFAULT = 16;

    // Slave register word offsets
    localparam logic [3:0] OFS_CTRL  = 4'd0;
    localparam logic [3:0] OFS_WADDR = 4'd2;
    localparam logic [3:0] OFS_AADDR = 4'd3;
    localparam logic [3:0] OFS_LEN   = 4'd5;

    typedef enum logic [2:0] {
        IDLE,
        REQ_W,
        WAIT_W,
        REQ_A,
        WAIT_A,
        MAC
    } state_t;

    // Byte address of 32-bit element idx within a vector starting at base
    function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/dotprod_accel_if.sv
// Avalon-MM bus bundle, used for both the CPU slave port and the SDRAM master port.
interface dotprod_accel_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              waitrequest;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              write;
    logic [DATA_W-1:0] writedata;

    modport master (
        output address, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/dotprod_fxp_mul.sv
// Combinational signed fixed-point multiply: full product, arithmetic shift, truncate.
module fxp_mul #(
    parameter int unsigned W         = 32,
    parameter int unsigned FRAC_BITS = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_p
);
    logic signed [2*W-1:0] w_a_ext;
    logic signed [2*W-1:0] w_b_ext;

    assign w_a_ext = {{W{i_a[W-1]}}, i_a};
    assign w_b_ext = {{W{i_b[W-1]}}, i_b};

    // Product of sign-extended operands is exact in 2W bits; keep W bits above the fraction
    assign o_p = W'((w_a_ext * w_b_ext) >>> FRAC_BITS);
endmodule

// File: rtl/dotprod_accel.sv
// Dot-product accelerator: CPU-configured, streams two vectors from SDRAM and
// returns their signed fixed-point dot product.
module dotprod_accel
    import dotprod_pkg::*;
#(
    parameter int unsigned FRAC_BITS = FRAC_BITS_DEFAULT,
    parameter int unsigned LEN_W     = 32
) (
    input logic              clk,
    input logic              rst_n,
    dotprod_accel_if.slave   avs,
    dotprod_accel_if.master  avm
);
    // Configuration registers (CPU visible)
    logic [31:0]      r_waddr;
    logic [31:0]      r_aaddr;
    logic [LEN_W-1:0] r_len;

    // Working state
    state_t           r_state;
    logic [31:0]      r_wbase;
    logic [31:0]      r_abase;
    logic [LEN_W-1:0] r_wlen;
    logic [LEN_W-1:0] r_idx;
    logic [31:0]      r_acc;
    logic [31:0]      r_result;
    logic [31:0]      r_w;
    logic [31:0]      r_a;
    logic             r_mread;
    logic [31:0]      r_maddr;

    logic             w_start;
    logic             w_waitreq;
    logic [31:0]      w_rdata;
    logic [31:0]      w_prod;
    logic [LEN_W-1:0] w_idx_next;

    fxp_mul #(
        .W         (32),
        .FRAC_BITS (FRAC_BITS)
    ) u_mul (
        .i_a (r_w),
        .i_b (r_a),
        .o_p (w_prod)
    );

    assign w_start    = avs.write && (avs.address == OFS_CTRL) && (r_state == IDLE);
    assign w_idx_next = r_idx + LEN_W'(1);

    // Configuration register writes; always accepted, even while a run is active
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_waddr <= '0;
            r_aaddr <= '0;
            r_len   <= '0;
        end else if (avs.write) begin
            case (avs.address)
                OFS_WADDR: r_waddr <= avs.writedata;
                OFS_AADDR: r_aaddr <= avs.writedata;
                OFS_LEN:   r_len   <= LEN_W'(avs.writedata);
                default:   ;
            endcase
        end
    end

    // Sequencer: one outstanding master read at a time, weight then activation, then MAC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wbase  <= '0;
            r_abase  <= '0;
            r_wlen   <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_w      <= '0;
            r_a      <= '0;
            r_mread  <= 1'b0;
            r_maddr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_wbase <= r_waddr;
                        r_abase <= r_aaddr;
                        r_wlen  <= r_len;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        if (r_len == '0) begin
                            r_result <= '0;
                        end else begin
                            r_state <= REQ_W;
                            r_mread <= 1'b1;
                            r_maddr <= r_waddr;
                        end
                    end
                end
                REQ_W: begin
                    if (!avm.waitrequest) begin
                        r_mread <= 1'b0;
                        r_state <= WAIT_W;
                    end
                end
                WAIT_W: begin
                    if (avm.readdatavalid) begin
                        r_w     <= avm.readdata;
                        r_mread <= 1'b1;
                        r_maddr <= elem_addr(r_abase, 32'(r_idx));
                        r_state <= REQ_A;
                    end
                end
                REQ_A: begin
                    if (!avm.waitrequest) begin
                        r_mread <= 1'b0;
                        r_state <= WAIT_A;
                    end
                end
                WAIT_A: begin
                    if (avm.readdatavalid) begin
                        r_a     <= avm.readdata;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod;
                    r_idx <= w_idx_next;
                    if (w_idx_next == r_wlen) begin
                        r_result <= r_acc + w_prod;
                        r_state  <= IDLE;
                    end else begin
                        r_mread <= 1'b1;
                        r_maddr <= elem_addr(r_wbase, 32'(w_idx_next));
                        r_state <= REQ_W;
                    end
                end
                default: begin
                    r_mread <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Zero-latency slave read path; only a result read stalls, and only while busy
    always_comb begin
        w_waitreq = avs.read && (avs.address == OFS_CTRL) && (r_state != IDLE);
        w_rdata   = '0;
        if (avs.read && !w_waitreq) begin
            case (avs.address)
                OFS_CTRL:  w_rdata = r_result;
                OFS_WADDR: w_rdata = r_waddr;
                OFS_AADDR: w_rdata = r_aaddr;
                OFS_LEN:   w_rdata = 32'(r_len);
                default:   w_rdata = '0;
            endcase
        end
    end

    assign avs.waitrequest   = w_waitreq;
    assign avs.readdata      = w_rdata;
    assign avs.readdatavalid = avs.read && !w_waitreq;

    assign avm.read      = r_mread;
    assign avm.address   = r_maddr;
    assign avm.write     = 1'b0;
    assign avm.writedata = '0;

endmodule

// File: tb/tb_dotprod_accel.sv
// Directed self-checking bench for dotprod_accel with a zero-wait SDRAM responder.
module tb_dotprod_accel;
    import dotprod_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dotprod_accel_if #(.ADDR_W(4))  cpu ();
    dotprod_accel_if #(.ADDR_W(32)) mbus ();

    dotprod_accel #(
        .FRAC_BITS (16),
        .LEN_W     (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .avs   (cpu),
        .avm   (mbus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] addr_log [$];
    bit          pending = 1'b0;
    logic [31:0] pend_data = '0;
    int          req_cnt = 0;
    int          stall_idx = -1;
    int          stall_left = 0;
    logic [31:0] stall_addr = '0;
    bit          rd_seen = 1'b0;

    logic [31:0] exp_basic [6] = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};
    logic [31:0] rd;
    int          stalls;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Caller is at posedge+1; returns at posedge+1
    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        cpu.address   = a;
        cpu.writedata = d;
        cpu.write     = 1'b1;
        @(posedge clk);
        #1;
        cpu.write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int n_stall);
        n_stall     = 0;
        cpu.address = a;
        cpu.read    = 1'b1;
        #1;
        while (cpu.waitrequest === 1'b1 && n_stall < 2000) begin
            @(posedge clk);
            #2;
            n_stall++;
        end
        if (n_stall >= 2000)
            check("read_timeout", 32'(n_stall), 32'd0);
        d = cpu.readdatavalid ? cpu.readdata : 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        cpu.read = 1'b0;
    endtask

    task automatic configure(input logic [31:0] wa, input logic [31:0] aa, input logic [31:0] len);
        cpu_write(OFS_WADDR, wa);
        cpu_write(OFS_AADDR, aa);
        cpu_write(OFS_LEN, len);
        addr_log.delete();
        req_cnt = 0;
        rd_seen = 1'b0;
    endtask

    // SDRAM responder: accepts a read when waitrequest is low, returns data the next cycle
    initial begin
        mbus.waitrequest   = 1'b0;
        mbus.readdata      = '0;
        mbus.readdatavalid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mbus.readdatavalid = 1'b0;
            if (pending) begin
                mbus.readdatavalid = 1'b1;
                mbus.readdata      = pend_data;
                pending            = 1'b0;
            end
            mbus.waitrequest = 1'b0;
            if (mbus.read === 1'b1) begin
                rd_seen = 1'b1;
                if (req_cnt == stall_idx && stall_left > 0) begin
                    mbus.waitrequest = 1'b1;
                    stall_left--;
                    check("stall_addr", mbus.address, stall_addr);
                    check("stall_read", {31'b0, mbus.read}, 32'd1);
                end else begin
                    addr_log.push_back(mbus.address);
                    pend_data = mem[mbus.address[13:2]];
                    pending   = 1'b1;
                    req_cnt++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        cpu.address   = '0;
        cpu.read      = 1'b0;
        cpu.write     = 1'b0;
        cpu.writedata = '0;
        for (int k = 0; k < 4096; k++) mem[k] = '0;
        mem[12'h400] = 32'h0001_0000;  // 0x1000
        mem[12'h401] = 32'h0002_0000;
        mem[12'h402] = 32'hFFFF_8000;
        mem[12'h800] = 32'h0002_0000;  // 0x2000
        mem[12'h801] = 32'h0000_8000;
        mem[12'h802] = 32'h0004_0000;
        mem[12'hC00] = 32'h7FFF_0000;  // 0x3000
        mem[12'hC40] = 32'h0002_0000;  // 0x3100
        mem[12'h440] = 32'h0003_0000;  // 0x1100
        mem[12'h441] = 32'hFFFF_0000;
        mem[12'h840] = 32'h0001_0000;  // 0x2100
        mem[12'h841] = 32'h0002_8000;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mread", {31'b0, mbus.read}, 32'd0);
        check("rst_maddr", mbus.address, 32'd0);
        check("rst_mwrite", mbus.write ? 32'd1 : mbus.writedata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cpu_read(OFS_CTRL, rd, stalls);
        check("rst_result", rd, 32'd0);
        check("rst_nostall", 32'(stalls), 32'd0);
        cpu_read(OFS_WADDR, rd, stalls);
        check("rst_waddr", rd, 32'd0);
        cpu_read(OFS_AADDR, rd, stalls);
        check("rst_aaddr", rd, 32'd0);
        cpu_read(OFS_LEN, rd, stalls);
        check("rst_len", rd, 32'd0);

        // Unmapped offset and readback
        cpu_write(4'd1, 32'h1234_5678);
        cpu_read(4'd1, rd, stalls);
        check("unmapped_read", rd, 32'd0);
        configure(32'h1000, 32'h2000, 32'd3);
        cpu_read(OFS_WADDR, rd, stalls);
        check("rb_waddr", rd, 32'h1000);
        cpu_read(OFS_AADDR, rd, stalls);
        check("rb_aaddr", rd, 32'h2000);
        cpu_read(OFS_LEN, rd, stalls);
        check("rb_len", rd, 32'd3);

        // Basic run: 1*2 + 2*0.5 + (-0.5)*4 = 1.0
        cpu_write(OFS_CTRL, 32'd1);
        cpu_read(OFS_CTRL, rd, stalls);
        check("basic_result", rd, 32'h0001_0000);
        check("basic_stalls", 32'(stalls), 32'd15);
        check("basic_nreq", 32'(addr_log.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            check($sformatf("basic_addr%0d", k),
                  (k < addr_log.size()) ? addr_log[k] : 32'hFFFF_FFFF, exp_basic[k]);

        // Zero length
        configure(32'h1000, 32'h2000, 32'd0);
        cpu_write(OFS_CTRL, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        cpu_read(OFS_CTRL, rd, stalls);
        check("zero_result", rd, 32'd0);
        check("zero_nostall", 32'(stalls), 32'd0);
        check("zero_no_mread", {31'b0, rd_seen}, 32'd0);

        // Backpressure: 5 stall cycles on the second request (0x2000)
        configure(32'h1000, 32'h2000, 32'd3);
        stall_idx  = 1;
        stall_left = 5;
        stall_addr = 32'h2000;
        cpu_write(OFS_CTRL, 32'd1);
        cpu_read(OFS_CTRL, rd, stalls);
        check("bp_result", rd, 32'h0001_0000);
        check("bp_stalls", 32'(stalls), 32'd20);
        check("bp_consumed", 32'(stall_left), 32'd0);
        check("bp_addr1", (addr_log.size() > 1) ? addr_log[1] : 32'hFFFF_FFFF, 32'h2000);
        stall_idx = -1;

        // Wrap: 32767.0 * 2.0 wraps to 0xFFFE0000
        configure(32'h3000, 32'h3100, 32'd1);
        cpu_write(OFS_CTRL, 32'd1);
        cpu_read(OFS_CTRL, rd, stalls);
        check("wrap_result", rd, 32'hFFFE_0000);
        check("wrap_stalls", 32'(stalls), 32'd5);

        // Start and config writes while busy
        configure(32'h1000, 32'h2000, 32'd3);
        cpu_write(OFS_CTRL, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        cpu_write(OFS_CTRL, 32'd1);
        cpu_write(OFS_WADDR, 32'h3000);
        cpu_read(OFS_CTRL, rd, stalls);
        check("busy_result", rd, 32'h0001_0000);
        check("busy_nreq", 32'(addr_log.size()), 32'd6);
        check("busy_addr4", (addr_log.size() > 4) ? addr_log[4] : 32'hFFFF_FFFF, 32'h1008);
        cpu_read(OFS_WADDR, rd, stalls);
        check("busy_waddr_rb", rd, 32'h3000);

        // Reset while the first request is held by waitrequest
        configure(32'h1000, 32'h2000, 32'd3);
        stall_idx  = 0;
        stall_left = 4;
        stall_addr = 32'h1000;
        cpu_write(OFS_CTRL, 32'd1);
        @(posedge clk);
        #1;
        check("midrst_pre_mread", {31'b0, mbus.read}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_mread", {31'b0, mbus.read}, 32'd0);
        rst_n      = 1'b1;
        stall_left = 0;
        stall_idx  = -1;
        @(posedge clk);
        #1;
        cpu_read(OFS_CTRL, rd, stalls);
        check("midrst_result", rd, 32'd0);
        check("midrst_idle", 32'(stalls), 32'd0);
        cpu_read(OFS_WADDR, rd, stalls);
        check("midrst_waddr", rd, 32'd0);
        cpu_read(OFS_AADDR, rd, stalls);
        check("midrst_aaddr", rd, 32'd0);
        cpu_read(OFS_LEN, rd, stalls);
        check("midrst_len", rd, 32'd0);

        // Reconfigure and restart: 3*1 + (-1)*2.5 = 0.5
        configure(32'h1100, 32'h2100, 32'd2);
        cpu_write(OFS_CTRL, 32'd1);
        cpu_read(OFS_CTRL, rd, stalls);
        check("re_result", rd, 32'h0000_8000);
        check("re_stalls", 32'(stalls), 32'd10);
        check("re_nreq", 32'(addr_log.size()), 32'd4);
        check("re_addr3", (addr_log.size() > 3) ? addr_log[3] : 32'hFFFF_FFFF, 32'h2104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dotprod_accel.md
Name: dotprod_accel

Overview:
- Avalon-MM accelerator component instantiated inside dnn_accel_system, alongside the SDRAM controller and hex display peripheral.
- The Nios II configures it through a slave port.
- It streams a weight vector and an activation vector out of SDRAM through a master port and returns their Q16.16 dot product.
- It is the compute stage that feeds results consumed by software and ultimately shown on the hex display.

Parameters:
- FRAC_BITS, 16, fractional bits of the signed fixed-point format (Q16.16 at default).
- LEN_W, 32, width of the element-count register and index counter.

Ports:
- clk  in  1  system clock (clk_clk domain).
- rst_n  in  1  synchronous active-low reset.
- slave_waitrequest  out  1  stall for CPU accesses.
- slave_address  in  4  word offset.
- slave_read  in  1  CPU read strobe.
- slave_readdata  out  32  CPU read data.
- slave_write  in  1  CPU write strobe.
- slave_writedata  in  32  CPU write data.
- master_waitrequest  in  1  interconnect stall.
- master_address  out  32  byte address to SDRAM.
- master_read  out  1  read request.
- master_readdata  in  32  returned word.
- master_readdatavalid  in  1  readdata qualifier.

Behaviour:
- Register map (word offsets):
  - 0: write = start; read = result, stalls while busy.
  - 2: W_ADDR, weight base byte address.
  - 3: A_ADDR, activation base byte address.
  - 5: LEN, element count.
  - Other offsets: writes ignored, reads return 0.
- Reset (rst_n low at a clk edge):
  - All registers, accumulator and index clear to 0.
  - FSM goes to IDLE.
  - master_read=0, master_address=0, slave_waitrequest=0, slave_readdata=0.
  - Reset mid-operation aborts immediately; master_read is low from the next edge, and any readdatavalid arriving afterwards is ignored.
- FSM states:
  - IDLE: a write to offset 0 latches W_ADDR/A_ADDR/LEN into working copies, clears acc and i, then goes to REQ_W. If LEN==0 it goes straight to IDLE with result=0 and issues no master reads.
  - REQ_W: master_read=1, master_address=W_ADDR+4*i. Address and read are held stable until master_waitrequest==0, then go to WAIT_W.
  - WAIT_W: wait for readdatavalid, capture w, go to REQ_A.
  - REQ_A: as REQ_W, using A_ADDR+4*i.
  - WAIT_A: on readdatavalid, capture a, go to MAC.
  - MAC: acc <= acc + prod, i <= i+1. If i+1==LEN, go to IDLE with result <= new acc; else go to REQ_W.
- Only one outstanding master read at any time.
- Arithmetic:
  - prod = signed 32x32 -> 64-bit product, arithmetic shift right by FRAC_BITS, truncated to 32 bits (bits [47:16] at default).
  - acc is 32-bit two's-complement and wraps silently; there is no saturation.
- Slave protocol:
  - Zero read latency: readdata is valid in the cycle slave_read && !slave_waitrequest.
  - slave_waitrequest is asserted only for a read of offset 0 while the FSM is not IDLE. It drops in the first cycle the FSM is IDLE, with readdata = final result.
  - Writes never stall.
  - A write to offset 0 while busy is ignored.
  - Config writes while busy update the registers but affect the next run only.
  - Registers read back their written values.
- Minimum latency with zero-wait memory: 5 cycles per element + 1 start cycle.

Decomposition:
- Package dotprod_pkg holds:
  - state enum (IDLE, REQ_W, WAIT_W, REQ_A, WAIT_A, MAC);
  - offset constants OFS_CTRL=0, OFS_WADDR=2, OFS_AADDR=3, OFS_LEN=5;
  - FRAC_BITS default.
- Sub-module fxp_mul: combinational signed Q-format multiply with shift and truncate, kept separate for reuse by later layers.

Test Plan:
- Reset: hold rst_n low 2 edges, then read offsets 0/2/3/5 -> all 0; master_read 0; slave_waitrequest 0.
- Basic run:
  - Stimulus: LEN=3, W=[0x00010000, 0x00020000, 0xFFFF8000], A=[0x00020000, 0x00008000, 0x00040000] at W_ADDR=0x1000, A_ADDR=0x2000; start, then read offset 0.
  - Required: waitrequest high until done, then readdata=0x00010000.
  - Required master address order: 0x1000, 0x2000, 0x1004, 0x2004, 0x1008, 0x2008.
- Zero length: LEN=0, start -> master_read never asserted; read offset 0 returns 0 with no stall.
- Master backpressure: master_waitrequest high for 5 cycles on the second request -> master_address/master_read held stable (0x2000), result unchanged at 0x00010000.
- Wrap: LEN=1, W=0x7FFF0000, A=0x00020000 -> result 0xFFFE0000.
- Mid-run events:
  - Write offset 0 during a run -> ignored, result still correct.
  - rst_n low mid-run -> master_read 0 after the edge, FSM IDLE, registers 0.
  - Reconfigure and restart -> correct result.
